scatter_ctrl: RTL and testbench
===============================

SCATTER_CTRL -- requirements
Module: scatter_ctrl

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16, meaning element width in bits (FP16).
REQ-002 SHALL have parameter IN_SIZE, default 4, meaning columns per beat.
REQ-003 SHALL have parameter IN_PARALLELISM, default 1, meaning rows per beat.
REQ-004 SHALL have parameter IN_DEPTH, default 8, meaning beats per tile.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port start, input, 1, single-cycle tile start request.
REQ-008 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-009 SHALL have port tile_done, output, 1, single-cycle tile-complete pulse.
REQ-010 SHALL have port large_count, output, CW=$clog2(IN_SIZE*IN_PARALLELISM*IN_DEPTH+1), count of nonzero large elements in the last or current tile.
REQ-011 SHALL have ports data_in_large and data_in_small, input, IN_WIDTH x IN_SIZE*IN_PARALLELISM each, scatter outputs.
REQ-012 SHALL have ports data_in_valid (input, 1) and data_in_ready (output, 1), the upstream handshake.
REQ-013 SHALL have ports data_out_large, data_out_large_valid and data_out_large_ready, with output/output/input directions and widths IN_WIDTH x IN_SIZE*IN_PARALLELISM/1/1, the large-path consumer.
REQ-014 SHALL have ports data_out_small, data_out_small_valid and data_out_small_ready, with the same directions and widths, the small-path consumer.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DRAIN.
REQ-016 SHALL move IDLE->RUN when start=1; start SHALL be ignored in RUN and DRAIN.
REQ-017 SHALL clear the beat counter and large_count on the IDLE->RUN transition.
REQ-018 SHALL drive data_in_ready=1 only in RUN, and only when each branch buffer is empty or its consumer ready is 1 in that cycle.
REQ-019 SHALL treat a beat as accepted when data_in_valid=1 and data_in_ready=1 in the same cycle.
REQ-020 SHALL load both branch buffers simultaneously on accept (fork); one branch SHALL never be loaded without the other.
REQ-021 SHALL have an accept-to-output latency of exactly 1 cycle: the branch valid goes high in the cycle after accept.
REQ-022 SHALL clear a branch buffer's valid flag when its consumer ready=1 and no load occurs in that cycle.
REQ-023 SHALL hold each branch's data and valid stable while that branch's ready=0.
REQ-024 SHALL let the two branches drain independently: backpressure on one branch SHALL NOT stall the other branch's already-buffered beat.
REQ-025 SHALL increment the beat counter on each accept and move RUN->DRAIN on the accept of beat IN_DEPTH-1; no further beats SHALL be accepted.
REQ-026 SHALL, on each accept, add to large_count the number of nonzero elements in data_in_large (saturating arithmetic is not needed; CW is sized for the tile maximum).
REQ-027 SHALL move DRAIN->IDLE when both branch buffers are empty.
REQ-028 SHALL assert tile_done as a registered pulse for exactly the first IDLE cycle after DRAIN.
REQ-029 SHALL accept a start received in that tile_done cycle.
REQ-030 SHALL hold large_count from tile_done until the next start.
REQ-031 SHALL, when IN_DEPTH=1, go RUN->DRAIN on the first accept.

Reset
REQ-032 SHALL, while rst=1, force state to IDLE, clear the beat counter, large_count, both buffer valid flags and buffer data, and drive busy=0, tile_done=0 and data_in_ready=0.
REQ-033 SHALL discard any in-flight tile on reset mid-operation and emit no tile_done for it.

Structure
REQ-034 SHALL place the FSM state enum typedef in a shared package scatter_ctrl_pkg.
REQ-035 SHALL implement the one-entry branch buffer as sub-module scatter_branch_buffer, instantiated twice (large and small).

Verification (IN_SIZE=4, IN_PARALLELISM=1, IN_DEPTH=4)
REQ-036 SHALL cover reset: rst pulse -> busy=0, tile_done=0, data_in_ready=0, both output valids=0, large_count=0.
REQ-037 SHALL cover the streaming tile: start, 4 valid beats back-to-back, both readies held 1 -> each beat appears on both outputs 1 cycle after accept, and tile_done pulses 1 cycle after the last beat leaves.
REQ-038 SHALL cover backpressure: data_out_small_ready=0 for 3 cycles after beat 0 -> data_in_ready=0 during those cycles, beat 0 held on the small branch, large branch drains beat 0, no beat lost or duplicated.
REQ-039 SHALL cover start while busy: start asserted at beat 2 -> ignored, and the tile completes after 4 beats.
REQ-040 SHALL cover reset mid-tile: rst after beat 1 -> all cleared with no tile_done; the next start gives a full 4-beat tile.
REQ-041 SHALL cover large_count: beats with 1, 0, 2 and 4 nonzero large elements -> large_count=7 at tile_done.

Source files
------------

// File: rtl/scatter_ctrl_pkg.sv
// Shared types for the scatter controller: FSM state encoding.
package scatter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/scatter_branch_buffer.sv
// One-entry output buffer for one scatter branch; output valid 1 cycle after load.
// Holds data/valid while the consumer stalls; free reports it can take a load this cycle.
module scatter_branch_buffer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             free
);

  assign free = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/scatter_ctrl.sv
// Tile controller forking each accepted beat into large/small branch buffers (1-cycle latency).
// Upstream is stalled unless both branches can take a beat; branches drain independently.
module scatter_ctrl
  import scatter_ctrl_pkg::*;
#(
  parameter int IN_WIDTH       = 16,
  parameter int IN_SIZE        = 4,
  parameter int IN_PARALLELISM = 1,
  parameter int IN_DEPTH       = 8,
  localparam int BUS = IN_WIDTH * IN_SIZE * IN_PARALLELISM,
  localparam int CW  = $clog2(IN_SIZE * IN_PARALLELISM * IN_DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           tile_done,
  output logic [CW-1:0]  large_count,
  input  logic [BUS-1:0] data_in_large,
  input  logic [BUS-1:0] data_in_small,
  input  logic           data_in_valid,
  output logic           data_in_ready,
  output logic [BUS-1:0] data_out_large,
  output logic           data_out_large_valid,
  input  logic           data_out_large_ready,
  output logic [BUS-1:0] data_out_small,
  output logic           data_out_small_valid,
  input  logic           data_out_small_ready
);

  localparam int N  = IN_SIZE * IN_PARALLELISM;
  localparam int BW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;

  state_t        state;
  logic [BW-1:0] beat_cnt;
  logic [CW-1:0] nz_large;
  logic          large_free;
  logic          small_free;
  logic          accept;
  logic          last_beat;

  assign data_in_ready = (state == RUN) && large_free && small_free;
  assign accept        = data_in_valid && data_in_ready;
  assign last_beat     = (beat_cnt == BW'(IN_DEPTH - 1));

  always_comb begin
    nz_large = '0;
    for (int i = 0; i < N; i++) begin
      if (data_in_large[i*IN_WIDTH +: IN_WIDTH] != '0) begin
        nz_large = nz_large + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      large_count <= '0;
      busy        <= 1'b0;
      tile_done   <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            beat_cnt    <= '0;
            large_count <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            beat_cnt    <= beat_cnt + BW'(1);
            large_count <= large_count + nz_large;
            if (last_beat) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // No loads happen in DRAIN, so free on both sides means both are empty from the next cycle.
          if (large_free && small_free) begin
            state     <= IDLE;
            busy      <= 1'b0;
            tile_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  scatter_branch_buffer #(.WIDTH(BUS)) u_large_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (data_in_large),
    .out_data  (data_out_large),
    .out_valid (data_out_large_valid),
    .out_ready (data_out_large_ready),
    .free      (large_free)
  );

  scatter_branch_buffer #(.WIDTH(BUS)) u_small_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (data_in_small),
    .out_data  (data_out_small),
    .out_valid (data_out_small_valid),
    .out_ready (data_out_small_ready),
    .free      (small_free)
  );

endmodule

// File: tb/tb_scatter_ctrl.sv
// Directed bench for scatter_ctrl with a per-branch scoreboard checked on every output cycle.
module tb_scatter_ctrl;

  localparam int BUS = 64;
  localparam int CW  = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           busy;
  logic           tile_done;
  logic [CW-1:0]  large_count;
  logic [BUS-1:0] data_in_large;
  logic [BUS-1:0] data_in_small;
  logic           data_in_valid;
  logic           data_in_ready;
  logic [BUS-1:0] data_out_large;
  logic           data_out_large_valid;
  logic           data_out_large_ready;
  logic [BUS-1:0] data_out_small;
  logic           data_out_small_valid;
  logic           data_out_small_ready;

  scatter_ctrl #(
    .IN_WIDTH(16), .IN_SIZE(4), .IN_PARALLELISM(1), .IN_DEPTH(4)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .busy                 (busy),
    .tile_done            (tile_done),
    .large_count          (large_count),
    .data_in_large        (data_in_large),
    .data_in_small        (data_in_small),
    .data_in_valid        (data_in_valid),
    .data_in_ready        (data_in_ready),
    .data_out_large       (data_out_large),
    .data_out_large_valid (data_out_large_valid),
    .data_out_large_ready (data_out_large_ready),
    .data_out_small       (data_out_small),
    .data_out_small_valid (data_out_small_valid),
    .data_out_small_ready (data_out_small_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BUS-1:0] d;
    int             cyc;
  } ent_t;

  ent_t lq[$];
  ent_t sq[$];
  int passed = 0;
  int total = 0;
  int n_accept = 0;
  int done_cnt = 0;
  int cyc = 0;
  bit pl_v = 0, pl_h = 0, ps_v = 0, ps_h = 0, pd = 0;

  // Large-branch beats carrying 1, 0, 2 and 4 nonzero FP16 elements.
  logic [BUS-1:0] lb [4] = '{64'h0000_0000_0000_1234, 64'h0000_0000_0000_0000,
                             64'h0001_0000_8000_0000, 64'hFFFF_0001_7C00_0002};
  logic [BUS-1:0] sb [4] = '{64'hA0A0_0000_0000_0001, 64'h0000_B1B1_0000_0002,
                             64'h0000_0000_C2C2_0003, 64'hD3D3_0000_0000_0004};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      lq.delete();
      sq.delete();
      pl_v = 0; pl_h = 0; ps_v = 0; ps_h = 0; pd = 0;
    end else begin
      if (data_out_large_valid) begin
        check("large_expected", lq.size() > 0, 1);
        if (lq.size() > 0) begin
          check("large_data", data_out_large, lq[0].d);
          if (!pl_v || pl_h) check("large_latency", cyc, lq[0].cyc + 1);
        end
      end
      pl_v = data_out_large_valid;
      pl_h = data_out_large_valid && data_out_large_ready;
      if (pl_h && lq.size() > 0) void'(lq.pop_front());

      if (data_out_small_valid) begin
        check("small_expected", sq.size() > 0, 1);
        if (sq.size() > 0) begin
          check("small_data", data_out_small, sq[0].d);
          if (!ps_v || ps_h) check("small_latency", cyc, sq[0].cyc + 1);
        end
      end
      ps_v = data_out_small_valid;
      ps_h = data_out_small_valid && data_out_small_ready;
      if (ps_h && sq.size() > 0) void'(sq.pop_front());

      if (data_in_valid && data_in_ready) begin
        lq.push_back('{data_in_large, cyc});
        sq.push_back('{data_in_small, cyc});
        n_accept++;
      end
      if (tile_done) begin
        check("tile_done_pulse", pd, 0);
        done_cnt++;
      end
      pd = tile_done;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [BUS-1:0] l, input logic [BUS-1:0] s);
    bit acc = 0;
    data_in_large = l;
    data_in_small = s;
    data_in_valid = 1'b1;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = data_in_ready;
      step();
    end
    check("send_accepted", acc, 1);
  endtask

  task automatic wait_done(input string tag);
    bit got = 0;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      got = tile_done;
    end
    check(tag, got, 1);
    step();
  endtask

  task automatic start_tile();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int a0, d0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; data_in_valid = 1'b0;
    data_in_large = '0; data_in_small = '0;
    data_out_large_ready = 1'b1; data_out_small_ready = 1'b1;

    // Reset state
    repeat (2) step();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_tile_done", tile_done, 0);
    check("rst_in_ready", data_in_ready, 0);
    check("rst_large_valid", data_out_large_valid, 0);
    check("rst_small_valid", data_out_small_valid, 0);
    check("rst_large_count", large_count, 0);
    step();
    rst = 1'b0;
    step();

    // Streaming tile, readies held high; nonzero counts 1+0+2+4
    a0 = n_accept;
    start_tile();
    @(negedge clk);
    check("run_busy", busy, 1);
    step();
    for (int i = 0; i < 4; i++) send(lb[i], sb[i]);
    data_in_valid = 1'b0;
    @(negedge clk);
    check("drain_in_ready", data_in_ready, 0);
    check("drain_busy", busy, 1);
    check("drain_no_done", tile_done, 0);
    step();
    @(negedge clk);
    check("stream_tile_done", tile_done, 1);
    check("stream_idle_busy", busy, 0);
    check("stream_large_count", large_count, 7);
    step();
    @(negedge clk);
    check("done_single_cycle", tile_done, 0);
    check("count_held", large_count, 7);
    step();
    check("stream_accepts", n_accept - a0, 4);

    // Small-branch backpressure for 3 cycles after beat 0
    a0 = n_accept;
    start_tile();
    send(lb[3], sb[0]);
    data_out_small_ready = 1'b0;
    data_in_large = lb[2]; data_in_small = sb[1]; data_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", data_in_ready, 0);
      check("bp_small_held", data_out_small_valid, 1);
      check("bp_large_drains", data_out_large_valid, (i == 0) ? 1 : 0);
      step();
    end
    data_out_small_ready = 1'b1;
    for (int i = 1; i < 4; i++) send(lb[i], sb[i]);
    data_in_valid = 1'b0;
    wait_done("bp_tile_done");
    check("bp_accepts", n_accept - a0, 4);
    check("bp_large_count", large_count, 4 + 0 + 2 + 4);

    // Start raised mid-tile is ignored
    a0 = n_accept;
    start_tile();
    send(lb[0], sb[3]);
    send(lb[1], sb[2]);
    start = 1'b1;
    send(lb[2], sb[1]);
    start = 1'b0;
    send(lb[3], sb[0]);
    data_in_valid = 1'b0;
    @(negedge clk);
    check("busy_start_in_ready", data_in_ready, 0);
    step();
    wait_done("busy_start_tile_done");
    check("busy_start_accepts", n_accept - a0, 4);
    @(negedge clk);
    check("busy_start_not_latched", busy, 0);
    step();

    // Reset mid-tile, then a clean full tile
    d0 = done_cnt;
    start_tile();
    send(lb[1], sb[1]);
    send(lb[2], sb[2]);
    data_in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", data_in_ready, 0);
    check("mid_rst_large_valid", data_out_large_valid, 0);
    check("mid_rst_small_valid", data_out_small_valid, 0);
    check("mid_rst_large_count", large_count, 0);
    check("mid_rst_tile_done", tile_done, 0);
    step();
    rst = 1'b0;
    repeat (6) step();
    check("mid_rst_no_done", done_cnt - d0, 0);
    a0 = n_accept;
    start_tile();
    for (int i = 0; i < 4; i++) send(lb[i], sb[i]);
    data_in_valid = 1'b0;
    wait_done("post_rst_tile_done");
    check("post_rst_accepts", n_accept - a0, 4);
    check("post_rst_large_count", large_count, 7);

    repeat (2) step();
    check("large_queue_empty", lq.size(), 0);
    check("small_queue_empty", sq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
